// File: rtl/cmvn_stream_pipe.sv
// Streaming cepstral mean/variance normaliser: out = sat(round((x - mean[k]) * istd[k] >> SHIFT)).
// Two-stage valid/ready pipeline (S1 subtract, S2 multiply/round/saturate) with a runtime-loadable coefficient bank.
module cmvn_stream_pipe #(
    parameter int DATA_W   = 32,
    parameter int NUM_FEAT = 20,
    parameter int ADDR_W   = 5,
    parameter int SHIFT    = 16,
    parameter int FCNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic              cfg_sel,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              out_sat,
    output logic              out_err,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int                    PW       = 2 * DATA_W + 1;
    localparam logic [ADDR_W:0]       NF       = (ADDR_W + 1)'(NUM_FEAT);
    localparam logic [ADDR_W-1:0]     LAST_IDX = ADDR_W'(NUM_FEAT - 1);
    localparam logic [DATA_W-1:0]     ISTD_ONE = DATA_W'(1) << SHIFT;
    localparam logic signed [PW-1:0]  MAXV     = {{(PW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [PW-1:0]  MINV     = {{(PW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic [DATA_W-1:0] mean_q [NUM_FEAT];
    logic [DATA_W-1:0] mean_d [NUM_FEAT];
    logic [DATA_W-1:0] istd_q [NUM_FEAT];
    logic [DATA_W-1:0] istd_d [NUM_FEAT];

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W:0]   s1_diff_q, s1_diff_d;
    logic [ADDR_W-1:0]        s1_addr_q, s1_addr_d;
    logic                     s1_byp_q, s1_byp_d;
    logic                     s1_err_q, s1_err_d;

    logic                     out_valid_q, out_valid_d;
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic [ADDR_W-1:0]        out_addr_q, out_addr_d;
    logic                     out_last_q, out_last_d;
    logic                     out_sat_q, out_sat_d;
    logic                     out_err_q, out_err_d;
    logic [FCNT_W-1:0]        frame_cnt_q, frame_cnt_d;

    logic                     advance, in_rdy, in_err;
    logic [DATA_W-1:0]        mean_rd, istd_rd;
    logic signed [PW-1:0]     diff_x, istd_x, prod, rnd, rsh;
    logic                     sat_hi, sat_lo;
    logic [DATA_W-1:0]        norm;

    always_comb begin
        advance = !out_valid_q || out_ready;
        in_rdy  = advance || !s1_valid_q;
        in_err  = {1'b0, in_addr} >= NF;

        mean_d = mean_q;
        istd_d = istd_q;
        if (cfg_we && ({1'b0, cfg_addr} < NF)) begin
            if (cfg_sel) istd_d[cfg_addr] = cfg_wdata;
            else         mean_d[cfg_addr] = cfg_wdata;
        end

        // Out-of-range indices never touch the bank; they read zero instead.
        mean_rd = in_err   ? '0 : mean_q[in_addr];
        istd_rd = s1_err_q ? '0 : istd_q[s1_addr_q];

        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_addr_d  = s1_addr_q;
        s1_byp_d   = s1_byp_q;
        s1_err_d   = s1_err_q;
        if (in_rdy) s1_valid_d = in_valid;
        if (in_rdy && in_valid) begin
            s1_diff_d = bypass ? {in_data[DATA_W-1], in_data}
                               : {in_data[DATA_W-1], in_data} - {mean_rd[DATA_W-1], mean_rd};
            s1_addr_d = in_addr;
            s1_byp_d  = bypass;
            s1_err_d  = in_err;
        end

        diff_x = {{(PW - DATA_W - 1){s1_diff_q[DATA_W]}}, s1_diff_q};
        istd_x = {{(PW - DATA_W){istd_rd[DATA_W-1]}}, istd_rd};
        prod   = diff_x * istd_x;
        rnd    = '0;
        rnd[SHIFT-1] = 1'b1;
        rsh    = (prod + rnd) >>> SHIFT;
        sat_hi = rsh > MAXV;
        sat_lo = rsh < MINV;
        norm   = sat_hi ? MAXV[DATA_W-1:0] : (sat_lo ? MINV[DATA_W-1:0] : rsh[DATA_W-1:0]);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        if (advance) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = s1_err_q ? '0 : (s1_byp_q ? s1_diff_q[DATA_W-1:0] : norm);
                out_addr_d = s1_addr_q;
                out_last_d = !s1_err_q && (s1_addr_q == LAST_IDX);
                out_sat_d  = !s1_err_q && !s1_byp_q && (sat_hi || sat_lo);
                out_err_d  = s1_err_q;
            end
        end

        frame_cnt_d = frame_cnt_q;
        if (out_valid_q && out_ready && out_last_q) frame_cnt_d = frame_cnt_q + FCNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_FEAT; i++) begin
                mean_q[i] <= '0;
                istd_q[i] <= ISTD_ONE;
            end
            s1_valid_q  <= 1'b0;
            s1_diff_q   <= '0;
            s1_addr_q   <= '0;
            s1_byp_q    <= 1'b0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            mean_q      <= mean_d;
            istd_q      <= istd_d;
            s1_valid_q  <= s1_valid_d;
            s1_diff_q   <= s1_diff_d;
            s1_addr_q   <= s1_addr_d;
            s1_byp_q    <= s1_byp_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign in_ready  = in_rdy;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;
    assign out_err   = out_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
